// File: rtl/cpu_control_unit.sv
// cpu_control_unit
// Multi-cycle control FSM for the 16-bit core. Each instruction takes four
// cycles: FETCH, DECODE, EXECUTE and WRITEBACK. The unit fetches from a
// synchronous ROM, latches the word into IR and decodes the datapath controls
// from IR. Conditional branches use the Z/P flags captured at the end of the
// last ALU or MOVI writeback.
module cpu_control_unit #(
    parameter int ADDR_W   = 8,
    parameter int RESET_PC = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [15:0]       instr_data,
    output logic              rf_write,
    output logic [2:0]        rs_addr,
    output logic [2:0]        rt_addr,
    output logic [2:0]        rd_addr,
    output logic [15:0]       imm_data,
    output logic [3:0]        alu_sel,
    output logic              imm_sel,
    output logic              mem_write,
    output logic              mem_sel,
    input  logic              zero_flag,
    input  logic              pos_flag,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [4:0] OP_LD   = 5'b10000;
    localparam logic [4:0] OP_ST   = 5'b10001;
    localparam logic [4:0] OP_MOVI = 5'b10110;
    localparam logic [4:0] OP_BZ   = 5'b11000;
    localparam logic [4:0] OP_BP   = 5'b11001;
    localparam logic [4:0] OP_JMP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11111;

    localparam logic [3:0]        ALU_PASS_B = 4'b1011;
    localparam logic [ADDR_W-1:0] PC_RST     = ADDR_W'(RESET_PC);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_q, pc_nxt;
    logic [15:0]       ir_q, ir_nxt;
    logic              z_q, z_nxt;
    logic              p_q, p_nxt;

    logic [4:0] op;
    logic [7:0] imm8;
    logic       is_alu, is_movi, is_ld, is_st, is_bz, is_bp, is_jmp, is_halt;
    logic       br_taken;

    // Branch target: pc + 1 + sign-extended imm8, wrapping modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] branch_target(
        input logic [ADDR_W-1:0] cur,
        input logic [7:0]        off
    );
        logic signed [7:0] off_s;
        off_s = off;
        return cur + ADDR_W'(1) + ADDR_W'(off_s);
    endfunction

    // Jump target: imm8 zero-extended or truncated to the PC width.
    function automatic logic [ADDR_W-1:0] jump_target(input logic [7:0] imm);
        return ADDR_W'(imm);
    endfunction

    assign op   = ir_q[15:11];
    assign imm8 = ir_q[7:0];

    assign is_alu  = ~op[4];
    assign is_movi = (op == OP_MOVI);
    assign is_ld   = (op == OP_LD);
    assign is_st   = (op == OP_ST);
    assign is_bz   = (op == OP_BZ);
    assign is_bp   = (op == OP_BP);
    assign is_jmp  = (op == OP_JMP);
    assign is_halt = (op == OP_HALT);

    // Branches only ever look at the latched flags, never the live datapath flags.
    assign br_taken = (is_bz & z_q) | (is_bp & p_q);

    // Datapath controls are pure decodes of IR, so they stay constant from
    // EXECUTE through WRITEBACK (IR only changes at the end of DECODE).
    always_comb begin
        rs_addr  = ir_q[7:5];
        rt_addr  = ir_q[4:2];
        rd_addr  = ir_q[10:8];
        imm_data = {8'h00, imm8};
        imm_sel  = is_movi;
        mem_sel  = is_ld;
        alu_sel  = 4'b0000;
        if (is_movi) begin
            alu_sel = ALU_PASS_B;
        end else if (is_alu) begin
            alu_sel = op[3:0];
        end
    end

    // Next-state, PC/IR/flag updates and the writeback strobes.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_nxt    = ir_q;
        z_nxt     = z_q;
        p_nxt     = p_q;
        rf_write  = 1'b0;
        mem_write = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                state_nxt = S_DECODE;
            end
            S_DECODE: begin
                ir_nxt    = instr_data;
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_halt) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_WRITEBACK;
                    if (br_taken) begin
                        pc_nxt = branch_target(pc_q, imm8);
                    end else if (is_jmp) begin
                        pc_nxt = jump_target(imm8);
                    end else begin
                        pc_nxt = pc_q + ADDR_W'(1);
                    end
                end
            end
            S_WRITEBACK: begin
                rf_write  = is_alu | is_movi | is_ld;
                mem_write = is_st;
                if (is_alu | is_movi) begin
                    z_nxt = zero_flag;
                    p_nxt = pos_flag;
                end
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, PC, IR and flag registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            pc_q  <= PC_RST;
            ir_q  <= 16'h0000;
            z_q   <= 1'b0;
            p_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            ir_q  <= ir_nxt;
            z_q   <= z_nxt;
            p_q   <= p_nxt;
        end
    end

    assign instr_addr = pc_q;
    assign pc         = pc_q;
    assign halted     = (state == S_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Testbench for cpu_control_unit: single-instruction vector table plus
// multi-instruction programs, with a write-strobe scoreboard.
module tb_cpu_control_unit;

    localparam int          ADDR_W = 8;
    localparam logic [15:0] I_HALT = 16'hF800;
    localparam logic [15:0] I_NOP  = 16'h9000;

    logic              clock;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] instr_addr;
    logic [15:0]       instr_data;
    logic              rf_write;
    logic [2:0]        rs_addr, rt_addr, rd_addr;
    logic [15:0]       imm_data;
    logic [3:0]        alu_sel;
    logic              imm_sel, mem_write, mem_sel;
    logic              zero_flag, pos_flag;
    logic              halted;
    logic [ADDR_W-1:0] pc;

    cpu_control_unit #(.ADDR_W(ADDR_W), .RESET_PC(0)) dut (
        .clock(clock), .reset(reset), .start(start),
        .instr_addr(instr_addr), .instr_data(instr_data),
        .rf_write(rf_write), .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .imm_data(imm_data), .alu_sel(alu_sel), .imm_sel(imm_sel),
        .mem_write(mem_write), .mem_sel(mem_sel),
        .zero_flag(zero_flag), .pos_flag(pos_flag),
        .halted(halted), .pc(pc)
    );

    logic [15:0] rom [256];

    always #5 clock = ~clock;

    // Synchronous instruction ROM: data appears one cycle after the address.
    always @(posedge clock) instr_data <= rom[instr_addr];

    typedef struct packed {
        logic [15:0] instr;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic [2:0]  rt;
        logic [15:0] imm;
        logic [3:0]  alu;
        logic        alu_chk;
        logic        isel;
        logic        msel;
        logic        rf;
        logic        mw;
        logic        hlt;
        logic [7:0]  pc_after;
    } vec_t;

    typedef struct packed {
        int         cyc;
        logic       rf;
        logic       mw;
        logic [2:0] rd;
        logic       msel;
    } sb_t;

    vec_t       vecs [9];
    sb_t        sb_q [$];
    int         n_chk;
    int         n_err;
    int         cyc;
    logic [255:0] fetched;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock; sample on the falling edge and score any write strobe.
    task automatic tick();
        sb_t e;
        @(posedge clock);
        cyc++;
        @(negedge clock);
        if (!$isunknown(instr_addr)) fetched[instr_addr] = 1'b1;
        if (rf_write === 1'b1 || mem_write === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sb_unexpected: rf_write=%0b mem_write=%0b at cycle %0d, expected no strobe",
                         rf_write, mem_write, cyc);
            end else begin
                e = sb_q.pop_front();
                chk("sb_cycle", 32'(cyc), 32'(e.cyc));
                chk("sb_rf_write", 32'(rf_write), 32'(e.rf));
                chk("sb_mem_write", 32'(mem_write), 32'(e.mw));
                chk("sb_mem_sel", 32'(mem_sel), 32'(e.msel));
                if (e.rf) chk("sb_rd_addr", 32'(rd_addr), 32'(e.rd));
            end
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic fill_rom(input logic [15:0] word);
        for (int a = 0; a < 256; a++) rom[a] = word;
    endtask

    task automatic run_until_halt(input int budget, input string nm);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_halted"}, 32'(halted), 32'd1);
    endtask

    task automatic push_sb(input int c, input logic rf, input logic mw,
                           input logic [2:0] rd, input logic msel);
        sb_t e;
        e.cyc = c; e.rf = rf; e.mw = mw; e.rd = rd; e.msel = msel;
        sb_q.push_back(e);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        clock = 1'b0; reset = 1'b1; start = 1'b0;
        zero_flag = 1'b0; pos_flag = 1'b0;
        n_chk = 0; n_err = 0; cyc = 0; fetched = '0;
        fill_rom(I_NOP);

        //                instr     rd    rs    rt    imm       alu   achk  isel  msel  rf    mw    hlt   pc
        vecs[0] = '{16'hB708, 3'd7, 3'd0, 3'd2, 16'h0008, 4'hB, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[1] = '{16'h1A70, 3'd2, 3'd3, 3'd4, 16'h0070, 4'h3, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[2] = '{16'h8520, 3'd5, 3'd1, 3'd0, 16'h0020, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01};
        vecs[3] = '{16'h8E50, 3'd6, 3'd2, 3'd4, 16'h0050, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h01};
        vecs[4] = '{16'hC005, 3'd0, 3'd0, 3'd1, 16'h0005, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[5] = '{16'hC803, 3'd0, 3'd0, 3'd0, 16'h0003, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[6] = '{16'hD042, 3'd0, 3'd2, 3'd0, 16'h0042, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h42};
        vecs[7] = '{16'h9000, 3'd0, 3'd0, 3'd0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h01};
        vecs[8] = '{16'hF800, 3'd0, 3'd0, 3'd0, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};

        // Reset state
        reset_dut();
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_instr_addr", 32'(instr_addr), 32'd0);
        chk("rst_strobes", 32'({rf_write, mem_write, halted}), 32'd0);
        chk("rst_regs", 32'({rs_addr, rt_addr, rd_addr}), 32'd0);
        chk("rst_imm_data", 32'(imm_data), 32'd0);
        chk("rst_sels", 32'({alu_sel, imm_sel, mem_sel}), 32'd0);

        // Single-instruction vectors, each from reset (latched Z = P = 0)
        for (int i = 0; i < 9; i++) begin
            v = vecs[i];
            reset_dut();
            fill_rom(I_HALT);
            rom[0] = v.instr;
            zero_flag = 1'b1;
            pos_flag  = 1'b1;
            if (v.rf || v.mw) push_sb(cyc + 4, v.rf, v.mw, v.rd, v.msel);
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
            tick();
            chk($sformatf("v%0d_rd_addr", i), 32'(rd_addr), 32'(v.rd));
            chk($sformatf("v%0d_rs_addr", i), 32'(rs_addr), 32'(v.rs));
            chk($sformatf("v%0d_rt_addr", i), 32'(rt_addr), 32'(v.rt));
            chk($sformatf("v%0d_imm_data", i), 32'(imm_data), 32'(v.imm));
            chk($sformatf("v%0d_imm_sel", i), 32'(imm_sel), 32'(v.isel));
            chk($sformatf("v%0d_mem_sel", i), 32'(mem_sel), 32'(v.msel));
            if (v.alu_chk) chk($sformatf("v%0d_alu_sel", i), 32'(alu_sel), 32'(v.alu));
            chk($sformatf("v%0d_no_early_strobe", i), 32'({rf_write, mem_write}), 32'd0);
            tick();
            chk($sformatf("v%0d_rf_write", i), 32'(rf_write), 32'(v.rf));
            chk($sformatf("v%0d_mem_write", i), 32'(mem_write), 32'(v.mw));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(v.pc_after));
            chk($sformatf("v%0d_halted", i), 32'(halted), 32'(v.hlt));
            chk($sformatf("v%0d_rd_hold", i), 32'(rd_addr), 32'(v.rd));
            chk($sformatf("v%0d_imm_hold", i), 32'(imm_data), 32'(v.imm));
            tick();
            chk($sformatf("v%0d_strobe_one_cycle", i), 32'({rf_write, mem_write}), 32'd0);
            chk($sformatf("v%0d_sb_drain", i), 32'(sb_q.size()), 32'd0);
        end

        // MOVI R1,#0 ; BZ +2 ; HALT ; NOP ; HALT  -- taken branch skips ROM[2]; start held high
        reset_dut();
        fill_rom(I_NOP);
        rom[0] = 16'hB100; rom[1] = 16'hC002; rom[2] = I_HALT; rom[4] = I_HALT;
        zero_flag = 1'b1; pos_flag = 1'b0;
        fetched = '0;
        push_sb(cyc + 4, 1'b1, 1'b0, 3'd1, 1'b0);
        start = 1'b1;
        tick();
        run_until_halt(40, "bz_taken");
        start = 1'b0;
        chk("bz_taken_pc", 32'(pc), 32'd4);
        chk("bz_rom2_not_fetched", 32'(fetched[2]), 32'd0);
        chk("bz_taken_sb_drain", 32'(sb_q.size()), 32'd0);

        // BZ -2 at pc 0: first pass not taken, then MOVI sets Z, JMP 0, taken wraps to 0xFF
        reset_dut();
        fill_rom(I_NOP);
        rom[0] = 16'hC0FE; rom[1] = 16'hB100; rom[2] = 16'hD000; rom[255] = I_HALT;
        zero_flag = 1'b1; pos_flag = 1'b0;
        push_sb(cyc + 8, 1'b1, 1'b0, 3'd1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_halt(60, "bz_wrap");
        chk("bz_wrap_pc", 32'(pc), 32'hFF);
        chk("bz_wrap_sb_drain", 32'(sb_q.size()), 32'd0);

        // MOVI R2,#5 with Z=0,P=1 ; BZ +8 not taken ; BP +3 taken to 6 ; HALT at 6
        reset_dut();
        fill_rom(I_NOP);
        rom[0] = 16'hB205; rom[1] = 16'hC008; rom[2] = 16'hC803; rom[6] = I_HALT; rom[10] = I_HALT;
        zero_flag = 1'b0; pos_flag = 1'b1;
        push_sb(cyc + 4, 1'b1, 1'b0, 3'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_halt(60, "bp_taken");
        chk("bp_taken_pc", 32'(pc), 32'd6);
        chk("bp_taken_sb_drain", 32'(sb_q.size()), 32'd0);

        // ST then LD
        reset_dut();
        fill_rom(I_NOP);
        rom[0] = 16'h8E50; rom[1] = 16'h8520; rom[2] = I_HALT;
        zero_flag = 1'b0; pos_flag = 1'b0;
        push_sb(cyc + 4, 1'b0, 1'b1, 3'd6, 1'b0);
        push_sb(cyc + 8, 1'b1, 1'b0, 3'd5, 1'b1);
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_halt(40, "st_ld");
        chk("st_ld_pc", 32'(pc), 32'd2);
        chk("st_ld_sb_drain", 32'(sb_q.size()), 32'd0);

        // Reset during WRITEBACK of an ALU op
        reset_dut();
        fill_rom(I_HALT);
        rom[0] = 16'h1A70;
        push_sb(cyc + 4, 1'b1, 1'b0, 3'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("rstwb_strobe_before", 32'(rf_write), 32'd1);
        reset = 1'b1;
        tick();
        chk("rstwb_rf_write", 32'(rf_write), 32'd0);
        chk("rstwb_pc", 32'(pc), 32'd0);
        chk("rstwb_halted", 32'(halted), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        tick();
        chk("rstwb_idle_pc", 32'(pc), 32'd0);
        chk("rstwb_idle_strobes", 32'({rf_write, mem_write}), 32'd0);

        // HALT ignores start pulses
        rom[0] = I_HALT;
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until_halt(10, "halt");
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            tick();
        end
        chk("halt_stays_halted", 32'(halted), 32'd1);
        chk("halt_pc_held", 32'(pc), 32'd0);
        chk("halt_no_strobes", 32'({rf_write, mem_write}), 32'd0);
        chk("final_sb_drain", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_control_unit.md
Name: cpu_control_unit

Overview:
- Multi-cycle control FSM that fetches 16-bit instructions from a synchronous instruction ROM, decodes them and sequences the existing 16-bit datapath through FETCH/DECODE/EXECUTE/WRITEBACK.
- Drives every datapath control input (register addresses, immediate, ALU select, mux selects, write strobes).
- Consumes the datapath zero/pos flags to resolve conditional branches.
- Sits between the instruction ROM and the datapath at CPU-core top level.

Parameters:
- ADDR_W, 8: PC / instruction address width; the PC wraps modulo 2^ADDR_W.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  leaves IDLE and begins execution at the current PC.
- instr_addr  output  ADDR_W  ROM address; ROM returns data one cycle later.
- instr_data  input  16  ROM read data.
- rf_write  output  1  register-file write strobe.
- rs_addr, rt_addr, rd_addr  output  3 each  register addresses.
- imm_data  output  16  immediate value, zero-extended imm8.
- alu_sel  output  4  ALU operation.
- imm_sel  output  1  1 = ALU B operand comes from imm_data.
- mem_write  output  1  data-memory write strobe.
- mem_sel  output  1  1 = register-file write data comes from data memory.
- zero_flag, pos_flag  input  1 each  datapath ALU result flags.
- halted  output  1  high in HALT.
- pc  output  ADDR_W  current PC, for debug.

Behaviour:
- Encoding:
  - op = IR[15:11], rd = IR[10:8], rs = IR[7:5], rt = IR[4:2], imm8 = IR[7:0].
  - op[4]=0: ALU R-type, alu_sel = op[3:0], imm_sel = 0, writes rd.
  - 10110 MOVI: imm_sel = 1, alu_sel = 1011 (pass B), imm_data = {8'h00, imm8}, writes rd.
  - 10000 LD: mem_sel = 1, writes rd.
  - 10001 ST: mem_write in WRITEBACK, no register write.
  - 11000 BZ: taken if latched Z = 1.
  - 11001 BP: taken if latched P = 1.
  - 11010 JMP: pc <= imm8 (truncated/zero-extended to ADDR_W).
  - 11111 HALT.
  - Any other opcode is a NOP: no strobes, pc+1.
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset:
  - state = IDLE, pc = RESET_PC, IR = 0, latched Z/P = 0.
  - All outputs 0 except pc = RESET_PC and instr_addr = RESET_PC.
- IDLE -> FETCH when start = 1; otherwise hold.
- FETCH: instr_addr = pc. Next state DECODE.
- DECODE:
  - IR <= instr_data.
  - rs/rt/rd/imm_data driven from the new IR starting the next cycle.
- EXECUTE:
  - alu_sel, imm_sel and mem_sel are valid.
  - PC update: taken BZ/BP gives pc <= pc + 1 + sext(imm8); JMP gives pc <= imm8; all others give pc <= pc + 1. All arithmetic is modulo 2^ADDR_W.
  - HALT opcode goes to HALT with pc unchanged.
- WRITEBACK:
  - rf_write = 1 for exactly one cycle for ALU, MOVI and LD.
  - mem_write = 1 for exactly one cycle for ST.
  - For ALU and MOVI only, Z <= zero_flag and P <= pos_flag at the end of this cycle.
  - Next state FETCH.
- Hold rules:
  - rs/rt/rd/imm_data/alu_sel/imm_sel/mem_sel are decoded from IR and held constant from the cycle after DECODE through WRITEBACK.
  - rf_write and mem_write are never both high and are 0 outside WRITEBACK.
- Latency: 4 cycles per instruction; a taken branch costs the same.
- HALT: halted = 1, all strobes 0, start ignored. Only reset exits.
- start while running: ignored.
- Reset mid-instruction: at the first rising edge with reset = 1, state -> IDLE and strobes drop. No partial write occurs after that edge.
- Branch flags come only from the latched Z/P. A branch right after reset sees Z = P = 0.

Test Plan:
- Reset, then start with ROM[0]=16'hB708 (MOVI R7,#8):
  - rf_write high exactly in cycle 4 after start.
  - rd_addr = 7, imm_data = 16'h0008, alu_sel = 4'b1011, imm_sel = 1.
  - pc = 1 afterwards.
- ROM[0..2] = MOVI R1,#0; BZ +2; HALT; ROM[4] = HALT:
  - BZ is taken (Z = 1 from the datapath).
  - Bench checks pc = 4 and halted = 1.
  - ROM[2] is never fetched.
- BP with P = 0 is not taken (pc + 1).
- BZ with imm8 = 8'hFE at pc = 0 wraps to pc = 8'hFF.
- ST then LD:
  - ST produces a single-cycle mem_write with rf_write = 0.
  - LD produces mem_sel = 1 with a single-cycle rf_write.
- Reset asserted during WRITEBACK of an ALU op:
  - Next cycle is IDLE with rf_write = 0 and pc = RESET_PC.
  - start pulses in HALT are ignored.
